// File: rtl/pair_triple_pattern_gen_if.sv
// Request and pattern stream bundle for the pair/triple pattern generator.
// The master side issues requests and consumes patterns; the slave side is the generator.
interface pair_triple_pattern_gen_if #(
   parameter int p_count_nbits = 4
);
   // Both channels use val/rdy: a transfer happens on a posedge where val and rdy
   // are both 1; the sender holds its payload stable while val=1 and rdy=0.
   logic                     req_val;
   logic                     req_rdy;
   logic [1:0]               req_mode;
   logic [p_count_nbits-1:0] req_count;
   logic                     out_val;
   logic                     out_rdy;
   logic                     out_in0;
   logic                     out_in1;
   logic                     out_in2;
   logic                     out_last;

   modport master (
      output req_val, req_mode, req_count, out_rdy,
      input  req_rdy, out_val, out_in0, out_in1, out_in2, out_last
   );

   modport slave (
      input  req_val, req_mode, req_count, out_rdy,
      output req_rdy, out_val, out_in0, out_in1, out_in2, out_last
   );
endinterface

// File: rtl/pair_triple_pattern_gen.sv
// Walks the eight 3-bit minterms and streams those whose 2-of-3 majority
// matches the requested class, a requested number of times.
module pair_triple_pattern_gen #(
   parameter int p_count_nbits = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   pair_triple_pattern_gen_if.slave     bus,
   output logic [1:0]                   state_dbg
);
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      SEND   = 2'd2
   } state_t;

   state_t                   state, state_n;
   logic [2:0]               idx, idx_n;
   logic [p_count_nbits-1:0] remaining, remaining_n;
   logic [1:0]               mode, mode_n;
   logic                     val_q, val_n;
   logic [2:0]               pat_q, pat_n;
   logic                     last_q, last_n;
   logic                     maj;
   logic                     match;

   assign maj   = (idx[2] & idx[1]) | (idx[2] & idx[0]) | (idx[1] & idx[0]);
   assign match = mode[1] | (mode[0] == maj);

   always_comb begin
      state_n     = state;
      idx_n       = idx;
      remaining_n = remaining;
      mode_n      = mode;
      val_n       = val_q;
      pat_n       = pat_q;
      last_n      = last_q;
      case (state)
         IDLE: begin
            val_n = 1'b0;
            if (bus.req_val) begin
               mode_n      = bus.req_mode;
               remaining_n = bus.req_count;
               if (bus.req_count != '0) state_n = SEARCH;
            end
         end
         SEARCH: begin
            idx_n = idx + 3'd1;
            if (match) begin
               pat_n   = idx;
               val_n   = 1'b1;
               last_n  = (remaining == p_count_nbits'(1));
               state_n = SEND;
            end
         end
         SEND: begin
            // idx stays put here so the next search resumes after the sent pattern
            if (bus.out_rdy) begin
               remaining_n = remaining - p_count_nbits'(1);
               val_n       = 1'b0;
               last_n      = 1'b0;
               state_n     = (remaining == p_count_nbits'(1)) ? IDLE : SEARCH;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= 3'd0;
         remaining <= '0;
         mode      <= 2'd0;
         val_q     <= 1'b0;
         pat_q     <= 3'd0;
         last_q    <= 1'b0;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         remaining <= remaining_n;
         mode      <= mode_n;
         val_q     <= val_n;
         pat_q     <= pat_n;
         last_q    <= last_n;
      end
   end

   assign bus.req_rdy  = (state == IDLE);
   assign bus.out_val  = val_q;
   assign bus.out_in0  = pat_q[2];
   assign bus.out_in1  = pat_q[1];
   assign bus.out_in2  = pat_q[0];
   assign bus.out_last = last_q;
   assign state_dbg    = state;
endmodule

// File: tb/tb_pair_triple_pattern_gen.sv
// Directed and randomized requests against a minterm-walk reference model;
// every beat, hold, gap and handshake readiness is checked with immediate assertions.
module tb_pair_triple_pattern_gen;
   logic       clk;
   logic       rst;
   logic [1:0] state_dbg;
   int         checks;
   int         failures;
   int         m_idx;

   pair_triple_pattern_gen_if #(.p_count_nbits(4)) bus ();

   pair_triple_pattern_gen #(.p_count_nbits(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Class membership from the plain definition: two or more of the three bits set.
   function automatic bit in_class(input int mode, input int v);
      bit [2:0] b;
      bit       maj;
      b   = v[2:0];
      maj = ($countones(b) >= 2);
      if (mode >= 2) return 1'b1;
      return (mode == 1) == maj;
   endfunction

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_idx = 0;
   endtask

   task automatic run_req(input int mode, input int cnt, input int stall_pct,
                          input int first_stall, input bit inject);
      logic [3:0] exp_q[$];
      logic [3:0] beat;
      logic [3:0] prev;
      bit         prev_stall;
      bit         prev_hs;
      int         budget;
      int         stalls_left;
      for (int k = 0; k < cnt; k++) begin
         while (!in_class(mode, m_idx)) m_idx = (m_idx + 1) % 8;
         exp_q.push_back({(k == cnt - 1) ? 1'b1 : 1'b0, 3'(m_idx)});
         m_idx = (m_idx + 1) % 8;
      end
      check("req_rdy_idle", {7'd0, bus.req_rdy}, 8'd1);
      bus.req_val   = 1'b1;
      bus.req_mode  = 2'(mode);
      bus.req_count = 4'(cnt);
      @(negedge clk);
      bus.req_val = 1'b0;
      check("latency_no_val", {7'd0, bus.out_val}, 8'd0);
      check("req_rdy_after_accept", {7'd0, bus.req_rdy}, (cnt == 0) ? 8'd1 : 8'd0);
      budget      = 0;
      prev_stall  = 1'b0;
      prev_hs     = 1'b0;
      prev        = '0;
      stalls_left = first_stall;
      while (exp_q.size() > 0 && budget < 300) begin
         budget++;
         if (prev_hs) check("gap_after_beat", {7'd0, bus.out_val}, 8'd0);
         prev_hs = 1'b0;
         if (bus.out_val) begin
            beat = {bus.out_last, bus.out_in0, bus.out_in1, bus.out_in2};
            check("beat", {4'd0, beat}, {4'd0, exp_q[0]});
            if (prev_stall) check("hold_while_stalled", {4'd0, beat}, {4'd0, prev});
            check("req_rdy_busy", {7'd0, bus.req_rdy}, 8'd0);
            if (stalls_left > 0) begin
               bus.out_rdy = 1'b0;
               stalls_left--;
            end else begin
               bus.out_rdy = ($urandom_range(99) >= stall_pct);
            end
            prev       = beat;
            prev_stall = !bus.out_rdy;
            if (bus.out_rdy) begin
               void'(exp_q.pop_front());
               prev_hs = 1'b1;
            end
         end else begin
            prev_stall  = 1'b0;
            bus.out_rdy = 1'($urandom_range(1));
            if (inject && budget == 1) begin
               check("req_rdy_midreq", {7'd0, bus.req_rdy}, 8'd0);
               bus.req_val   = 1'b1;
               bus.req_mode  = 2'd1;
               bus.req_count = 4'd2;
            end
         end
         @(negedge clk);
         bus.req_val = 1'b0;
      end
      check("stream_complete", 8'(exp_q.size()), 8'd0);
      check("out_val_after", {7'd0, bus.out_val}, 8'd0);
      check("req_rdy_after", {7'd0, bus.req_rdy}, 8'd1);
      bus.out_rdy = 1'b0;
   endtask

   initial begin
      int budget;
      checks        = 0;
      failures      = 0;
      m_idx         = 0;
      rst           = 1'b1;
      bus.req_val   = 1'b0;
      bus.req_mode  = 2'd0;
      bus.req_count = 4'd0;
      bus.out_rdy   = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_out_val", {7'd0, bus.out_val}, 8'd0);
      check("reset_out_last", {7'd0, bus.out_last}, 8'd0);
      check("reset_pattern", {5'd0, bus.out_in0, bus.out_in1, bus.out_in2}, 8'd0);
      check("reset_req_rdy", {7'd0, bus.req_rdy}, 8'd1);
      rst = 1'b0;
      @(negedge clk);

      // majority class: 011,101,110,111
      run_req(1, 4, 0, 0, 1'b0);
      // minority class with wrap back to 000
      pulse_reset();
      run_req(0, 5, 0, 0, 1'b0);
      // all patterns, first beat stalled three cycles
      pulse_reset();
      run_req(2, 3, 0, 3, 1'b0);
      // empty request
      run_req(0, 0, 0, 0, 1'b0);
      // request attempted while busy must be ignored
      run_req(0, 3, 0, 0, 1'b1);

      for (int r = 0; r < 12; r++) begin
         run_req(int'($urandom_range(3)), int'($urandom_range(15)),
                 int'($urandom_range(60)), 0, 1'($urandom_range(1)));
      end

      // reset while a pattern is pending
      bus.out_rdy   = 1'b0;
      bus.req_val   = 1'b1;
      bus.req_mode  = 2'd2;
      bus.req_count = 4'd3;
      @(negedge clk);
      bus.req_val = 1'b0;
      budget = 0;
      while (!bus.out_val && budget < 10) begin
         budget++;
         @(negedge clk);
      end
      check("pending_before_reset", {7'd0, bus.out_val}, 8'd1);
      pulse_reset();
      check("rst_drop_val", {7'd0, bus.out_val}, 8'd0);
      check("rst_drop_last", {7'd0, bus.out_last}, 8'd0);
      check("rst_drop_pattern", {5'd0, bus.out_in0, bus.out_in1, bus.out_in2}, 8'd0);
      run_req(1, 2, 0, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
